// File: rtl/debug_unit_if.sv
// Byte-level handshake between debug_unit and the UART receiver/transmitter pair.
// The master modport is the debug engine side, the slave modport is the UART side.
interface debug_unit_if #(
  parameter int NB_DATA = 8
);
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done;
  logic               tx_done;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;

  modport master (input rx_data, rx_done, tx_done, output tx_data, tx_start);
  modport slave  (output rx_data, rx_done, tx_done, input tx_data, tx_start);
endinterface

// File: rtl/debug_unit.sv
// Host-side debug engine for the MIPS pipeline: decodes UART commands, steps or runs
// the pipeline, and streams a 140-byte snapshot (PC, cycles, regs, data word) back out.
module debug_unit #(
  parameter int                 N_BITS   = 32,
  parameter int                 NB_DATA  = 8,
  parameter logic [NB_DATA-1:0] CMD_CONT = 8'h63,
  parameter logic [NB_DATA-1:0] CMD_STEP = 8'h73,
  parameter logic [NB_DATA-1:0] CMD_NEXT = 8'h6E
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  debug_unit_if.master         uart,
  input  logic [N_BITS-1:0]    i_pc,
  input  logic [N_BITS-1:0]    i_ciclos,
  input  logic [N_BITS*32-1:0] i_registros,
  input  logic [N_BITS-1:0]    i_data_memory,
  input  logic                 i_halt,
  output logic                 o_valid,
  output logic                 o_exec_mode,
  output logic                 o_step,
  output logic                 o_busy
);

  localparam int         N_WORDS     = 35;
  localparam int         FRAME_BITS  = N_BITS * N_WORDS;
  localparam int         FRAME_BYTES = FRAME_BITS / NB_DATA;
  localparam logic [7:0] LAST_IDX    = 8'(FRAME_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, RUN, STEP_IDLE, STEP_PULSE, SETTLE, SNAP, SEND, WAIT_TX, DONE
  } state_t;

  state_t                state;
  logic [FRAME_BITS-1:0] frame;
  logic [FRAME_BITS-1:0] snap_frame;
  logic [7:0]            idx;
  logic                  from_run;
  logic                  snap_halt;
  logic [NB_DATA-1:0]    tx_data;
  logic                  tx_start;

  assign uart.tx_data  = tx_data;
  assign uart.tx_start = tx_start;

  // Byte 0 of the frame sits in the top bits so a left shift walks it MSB-first.
  function automatic logic [NB_DATA-1:0] frame_byte(input logic [FRAME_BITS-1:0] f,
                                                    input logic [7:0]            b);
    logic [FRAME_BITS-1:0] sh;
    sh = f << (NB_DATA * int'(b));
    return sh[FRAME_BITS-1 -: NB_DATA];
  endfunction

  // NOTE: every always_comb output gets a full default first so no latch can be inferred.
  always_comb begin
    snap_frame = '0;
    snap_frame[FRAME_BITS-1 -: N_BITS]          = i_pc;
    snap_frame[FRAME_BITS-1-N_BITS -: N_BITS]   = i_ciclos;
    for (int k = 0; k < 32; k++) begin
      snap_frame[FRAME_BITS-1-(2+k)*N_BITS -: N_BITS] = i_registros[k*N_BITS +: N_BITS];
    end
    snap_frame[N_BITS-1:0] = i_data_memory;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      // NOTE: the frame buffer is plain flops, not a RAM macro, so it is cleared here.
      frame       <= '0;
      idx         <= '0;
      from_run    <= 1'b0;
      snap_halt   <= 1'b0;
      o_valid     <= 1'b0;
      o_exec_mode <= 1'b0;
      o_step      <= 1'b0;
      o_busy      <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
    end else begin
      o_step   <= 1'b0;
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (uart.rx_done && uart.rx_data == CMD_CONT) begin
            o_valid     <= 1'b1;
            o_exec_mode <= 1'b0;
            from_run    <= 1'b1;
            state       <= RUN;
          end else if (uart.rx_done && uart.rx_data == CMD_STEP) begin
            o_valid     <= 1'b1;
            o_exec_mode <= 1'b1;
            from_run    <= 1'b0;
            state       <= STEP_IDLE;
          end
        end
        RUN: begin
          if (i_halt) begin
            o_valid <= 1'b0;
            o_busy  <= 1'b1;
            state   <= SNAP;
          end
        end
        STEP_IDLE: begin
          // Halt outranks a same-cycle command; that halt state was already dumped.
          if (i_halt) begin
            o_valid <= 1'b0;
            state   <= DONE;
          end else if (uart.rx_done && uart.rx_data == CMD_NEXT) begin
            o_step <= 1'b1;
            state  <= STEP_PULSE;
          end
        end
        STEP_PULSE: state <= SETTLE;
        SETTLE: begin
          o_busy <= 1'b1;
          state  <= SNAP;
        end
        SNAP: begin
          frame     <= snap_frame;
          snap_halt <= i_halt;
          idx       <= '0;
          tx_data   <= snap_frame[FRAME_BITS-1 -: NB_DATA];
          tx_start  <= 1'b1;
          state     <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (uart.tx_done) begin
            if (idx != LAST_IDX) begin
              idx      <= idx + 8'd1;
              tx_data  <= frame_byte(frame, idx + 8'd1);
              tx_start <= 1'b1;
              state    <= SEND;
            end else begin
              o_busy <= 1'b0;
              if (from_run || snap_halt) begin
                o_valid <= 1'b0;
                state   <= DONE;
              end else begin
                state <= STEP_IDLE;
              end
            end
          end
        end
        DONE:    o_valid <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: command decode, step/run dumps, frame contents,
// handshake timing, snapshot freeze and reset mid-dump.
module tb_debug_unit;

  localparam int         N_BITS   = 32;
  localparam int         NB_DATA  = 8;
  localparam logic [7:0] CMD_CONT = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_NEXT = 8'h6E;

  logic                 clk;
  logic                 rst;
  logic [N_BITS-1:0]    pc;
  logic [N_BITS-1:0]    ciclos;
  logic [N_BITS*32-1:0] regs;
  logic [N_BITS-1:0]    dmem;
  logic                 halt;
  logic                 valid;
  logic                 exec_mode;
  logic                 step;
  logic                 busy;

  debug_unit_if #(.NB_DATA(NB_DATA)) uart ();

  debug_unit #(
    .N_BITS(N_BITS), .NB_DATA(NB_DATA),
    .CMD_CONT(CMD_CONT), .CMD_STEP(CMD_STEP), .CMD_NEXT(CMD_NEXT)
  ) dut (
    .i_clk(clk), .i_reset(rst), .uart(uart),
    .i_pc(pc), .i_ciclos(ciclos), .i_registros(regs), .i_data_memory(dmem),
    .i_halt(halt), .o_valid(valid), .o_exec_mode(exec_mode), .o_step(step),
    .o_busy(busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_starts = 0;
  int         n_dones = 0;
  int         n_steps = 0;
  int         resp_cnt = 0;
  logic [7:0] rec       [0:1023];
  int         start_cyc [0:1023];
  int         done_cyc  [0:1023];
  int         step_cyc  [0:15];

  logic [31:0] m_pc, m_cyc, m_dm;
  logic [31:0] m_regs [32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  // UART transmitter model and output log: answers each start with done 3 cycles later.
  initial begin
    uart.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      uart.tx_done = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          uart.tx_done = 1'b1;
          if (n_dones < 1024) done_cyc[n_dones] = cyc;
          n_dones++;
        end
      end
      if (uart.tx_start === 1'b1) begin
        if (n_starts < 1024) begin
          rec[n_starts]       = uart.tx_data;
          start_cyc[n_starts] = cyc;
        end
        n_starts++;
        resp_cnt = 3;
      end
      if (step === 1'b1) begin
        if (n_steps < 16) step_cyc[n_steps] = cyc;
        n_steps++;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int b);
    logic [31:0] w;
    int          wi;
    wi = b / 4;
    if (wi == 0)      w = m_pc;
    else if (wi == 1) w = m_cyc;
    else if (wi < 34) w = m_regs[wi-2];
    else              w = m_dm;
    return 8'(w >> (8 * (3 - (b % 4))));
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_model();
    pc     = m_pc;
    ciclos = m_cyc;
    dmem   = m_dm;
    for (int k = 0; k < 32; k++) regs[k*32 +: 32] = m_regs[k];
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    uart.rx_done = 1'b0;
    halt         = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, output int t);
    uart.rx_data = b;
    uart.rx_done = 1'b1;
    t = cyc;
    tick();
    uart.rx_done = 1'b0;
  endtask

  task automatic wait_starts(input int target, input string name);
    int n = 0;
    while (n_starts < target && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s wait: starts=%0d required>=%0d", name, n_starts, target);
    end
  endtask

  task automatic wait_dump(input int sbase, input string name);
    int n = 0;
    while ((n_starts < sbase + 140 || busy !== 1'b0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s dump timeout: starts=%0d busy=%b required starts=%0d busy=0",
               name, n_starts - sbase, busy, 140);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 6;
    if (valid !== 1'b0)         begin errors++; $display("FAIL rst_valid got %b required 0", valid); end
    if (exec_mode !== 1'b0)     begin errors++; $display("FAIL rst_exec got %b required 0", exec_mode); end
    if (step !== 1'b0)          begin errors++; $display("FAIL rst_step got %b required 0", step); end
    if (uart.tx_data !== 8'h00) begin errors++; $display("FAIL rst_txdata got %h required 00", uart.tx_data); end
    if (uart.tx_start !== 1'b0) begin errors++; $display("FAIL rst_txstart got %b required 0", uart.tx_start); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
  endtask

  task automatic test_ignored_idle();
    int t, s0, st0;
    apply_reset();
    s0 = n_starts; st0 = n_steps;
    send_byte(8'h41, t);
    send_byte(CMD_NEXT, t);
    repeat (5) tick();
    checks += 4;
    if (valid !== 1'b0)     begin errors++; $display("FAIL idle_ign_valid got %b required 0", valid); end
    if (exec_mode !== 1'b0) begin errors++; $display("FAIL idle_ign_exec got %b required 0", exec_mode); end
    if (n_steps != st0)     begin errors++; $display("FAIL idle_ign_step got %0d pulses required 0", n_steps - st0); end
    if (n_starts != s0)     begin errors++; $display("FAIL idle_ign_tx got %0d starts required 0", n_starts - s0); end
    send_byte(CMD_STEP, t);
    checks += 2;
    if (valid !== 1'b1)     begin errors++; $display("FAIL idle_then_step_valid got %b required 1", valid); end
    if (exec_mode !== 1'b1) begin errors++; $display("FAIL idle_then_step_exec got %b required 1", exec_mode); end
  endtask

  task automatic test_continuous_halt();
    int t, th, sb, db;
    apply_reset();
    m_pc = 32'h0000_0010; m_cyc = 32'h0000_002A; m_dm = 32'hDEAD_BEEF;
    for (int k = 0; k < 32; k++) m_regs[k] = 32'(k);
    drive_model();
    sb = n_starts; db = n_dones;
    send_byte(CMD_CONT, t);
    checks += 2;
    if (valid !== 1'b1)     begin errors++; $display("FAIL cont_valid got %b required 1", valid); end
    if (exec_mode !== 1'b0) begin errors++; $display("FAIL cont_exec got %b required 0", exec_mode); end
    repeat (3) tick();
    checks++;
    if (n_starts != sb) begin errors++; $display("FAIL cont_early_tx got %0d starts required 0", n_starts - sb); end
    halt = 1'b1;
    th   = cyc;
    tick();
    checks += 2;
    if (valid !== 1'b0) begin errors++; $display("FAIL cont_halt_valid got %b required 0", valid); end
    if (busy !== 1'b1)  begin errors++; $display("FAIL cont_halt_busy got %b required 1", busy); end
    wait_starts(sb + 20, "cont_mid");
    send_byte(CMD_CONT, t);
    wait_dump(sb, "cont");
    checks += 4;
    if (n_starts - sb != 140)   begin errors++; $display("FAIL cont_count got %0d required 140", n_starts - sb); end
    if (start_cyc[sb] != th + 2) begin errors++; $display("FAIL cont_first_start got cycle %0d required %0d", start_cyc[sb], th + 2); end
    if (valid !== 1'b0)         begin errors++; $display("FAIL cont_done_valid got %b required 0", valid); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL cont_done_busy got %b required 0", busy); end
    for (int b = 0; b < 140; b++) begin
      logic [7:0] e;
      e = exp_byte(b);
      checks++;
      if (rec[sb+b] !== e) begin errors++; $display("FAIL cont_byte[%0d] got %h required %h", b, rec[sb+b], e); end
    end
    for (int i = 0; i < 139; i++) begin
      checks++;
      if (start_cyc[sb+i+1] != done_cyc[db+i] + 1) begin
        errors++;
        $display("FAIL cont_gap[%0d] start at %0d required %0d", i + 1, start_cyc[sb+i+1], done_cyc[db+i] + 1);
      end
    end
    send_byte(CMD_STEP, t);
    repeat (10) tick();
    checks += 3;
    if (valid !== 1'b0)        begin errors++; $display("FAIL done_ign_valid got %b required 0", valid); end
    if (exec_mode !== 1'b0)    begin errors++; $display("FAIL done_ign_exec got %b required 0", exec_mode); end
    if (n_starts - sb != 140)  begin errors++; $display("FAIL done_ign_tx got %0d starts required 140", n_starts - sb); end
  endtask

  task automatic test_single_step();
    int t, t2, sb, st0, sb2;
    apply_reset();
    m_pc = 32'h0000_0100; m_cyc = 32'h0000_0005; m_dm = 32'h1234_5678;
    for (int k = 0; k < 32; k++) m_regs[k] = 32'hA000_0000 | (32'(k) * 32'h0101);
    drive_model();
    sb = n_starts; st0 = n_steps;
    send_byte(CMD_STEP, t);
    checks += 2;
    if (valid !== 1'b1)     begin errors++; $display("FAIL step_valid got %b required 1", valid); end
    if (exec_mode !== 1'b1) begin errors++; $display("FAIL step_exec got %b required 1", exec_mode); end
    repeat (2) tick();
    checks++;
    if (n_steps != st0) begin errors++; $display("FAIL step_no_pulse got %0d required 0", n_steps - st0); end
    send_byte(CMD_NEXT, t);
    wait_dump(sb, "step1");
    checks += 5;
    if (n_steps - st0 != 1)     begin errors++; $display("FAIL step1_pulses got %0d required 1", n_steps - st0); end
    if (step_cyc[st0] != t + 1) begin errors++; $display("FAIL step1_pulse_cycle got %0d required %0d", step_cyc[st0], t + 1); end
    if (start_cyc[sb] != t + 4) begin errors++; $display("FAIL step1_first_start got %0d required %0d", start_cyc[sb], t + 4); end
    if (n_starts - sb != 140)   begin errors++; $display("FAIL step1_count got %0d required 140", n_starts - sb); end
    if (valid !== 1'b1)         begin errors++; $display("FAIL step1_valid_after got %b required 1", valid); end
    for (int b = 0; b < 140; b++) begin
      logic [7:0] e;
      e = exp_byte(b);
      checks++;
      if (rec[sb+b] !== e) begin errors++; $display("FAIL step1_byte[%0d] got %h required %h", b, rec[sb+b], e); end
    end
    // Second step; the PC input is corrupted after the snapshot to prove the freeze.
    m_pc = 32'h0000_0104; m_cyc = 32'h0000_0006;
    drive_model();
    sb2 = n_starts;
    send_byte(CMD_NEXT, t2);
    wait_starts(sb2 + 2, "step2_mid");
    pc = 32'hFFFF_FFFF;
    send_byte(CMD_NEXT, t);
    wait_dump(sb2, "step2");
    checks += 3;
    if (n_steps - st0 != 2)        begin errors++; $display("FAIL step2_pulses got %0d required 2", n_steps - st0); end
    if (step_cyc[st0+1] != t2 + 1) begin errors++; $display("FAIL step2_pulse_cycle got %0d required %0d", step_cyc[st0+1], t2 + 1); end
    if (n_starts - sb2 != 140)     begin errors++; $display("FAIL step2_count got %0d required 140", n_starts - sb2); end
    for (int b = 0; b < 140; b++) begin
      logic [7:0] e;
      e = exp_byte(b);
      checks++;
      if (rec[sb2+b] !== e) begin errors++; $display("FAIL freeze_byte[%0d] got %h required %h", b, rec[sb2+b], e); end
    end
    // Halt and a step command in the same cycle: halt wins, no pulse.
    pc           = m_pc;
    halt         = 1'b1;
    uart.rx_data = CMD_NEXT;
    uart.rx_done = 1'b1;
    tick();
    uart.rx_done = 1'b0;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL step_halt_valid got %b required 0", valid); end
    repeat (6) tick();
    checks += 2;
    if (n_steps - st0 != 2)     begin errors++; $display("FAIL step_halt_pulses got %0d required 2", n_steps - st0); end
    if (n_starts - sb2 != 140)  begin errors++; $display("FAIL step_halt_tx got %0d required 140", n_starts - sb2); end
  endtask

  task automatic test_reset_mid_dump();
    int t, sb, ns, st0;
    apply_reset();
    m_pc = 32'h0000_0200; m_cyc = 32'h0000_0077; m_dm = 32'hCAFE_F00D;
    for (int k = 0; k < 32; k++) m_regs[k] = ~32'(k);
    drive_model();
    sb = n_starts; st0 = n_steps;
    send_byte(CMD_CONT, t);
    halt = 1'b1;
    wait_starts(sb + 50, "rst_mid");
    rst = 1'b1;
    ns  = n_starts;
    tick();
    checks += 6;
    if (valid !== 1'b0)         begin errors++; $display("FAIL rstmid_valid got %b required 0", valid); end
    if (exec_mode !== 1'b0)     begin errors++; $display("FAIL rstmid_exec got %b required 0", exec_mode); end
    if (step !== 1'b0)          begin errors++; $display("FAIL rstmid_step got %b required 0", step); end
    if (uart.tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_txdata got %h required 00", uart.tx_data); end
    if (uart.tx_start !== 1'b0) begin errors++; $display("FAIL rstmid_txstart got %b required 0", uart.tx_start); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL rstmid_busy got %b required 0", busy); end
    rst  = 1'b0;
    halt = 1'b0;
    repeat (20) tick();
    checks++;
    if (n_starts != ns) begin errors++; $display("FAIL rstmid_no_tx got %0d extra starts required 0", n_starts - ns); end
    send_byte(CMD_STEP, t);
    checks += 2;
    if (valid !== 1'b1)     begin errors++; $display("FAIL rstmid_step_valid got %b required 1", valid); end
    if (exec_mode !== 1'b1) begin errors++; $display("FAIL rstmid_step_exec got %b required 1", exec_mode); end
    repeat (10) tick();
    checks += 2;
    if (n_starts != ns)  begin errors++; $display("FAIL rstmid_idle_tx got %0d extra starts required 0", n_starts - ns); end
    if (n_steps != st0)  begin errors++; $display("FAIL rstmid_idle_step got %0d pulses required 0", n_steps - st0); end
  endtask

  initial begin
    rst          = 1'b1;
    halt         = 1'b0;
    pc           = '0;
    ciclos       = '0;
    regs         = '0;
    dmem         = '0;
    uart.rx_data = '0;
    uart.rx_done = 1'b0;
    test_reset();
    test_ignored_idle();
    test_continuous_halt();
    test_single_step();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
